// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational single-cycle ALU; flags err for any opcode it does not implement.
module alu_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_SLT: y[0] = $signed(a) < $signed(b);
      OP_NOR: y = ~(a | b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops through alu_seq_alu, shift-add multiply
// iterated locally, valid/ready handshakes on both request and response.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [3:0]       op_c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] alu_y, res;
  logic             alu_err, op_is_mul;

  assign op_is_mul = is_mul_op(op_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = is_mul_op(req_op) ? MUL : RESP;
      MUL:  if (cnt == CNT_LAST) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // During MUL op_a/op_b double as the shifting multiplicand/multiplier;
  // the ALU output is ignored for MUL so clobbering them is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      op_c <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_a <= req_a;
          op_b <= req_b;
          op_c <= req_op;
          acc  <= '0;
          cnt  <= '0;
        end
        MUL: begin
          if (op_b[0]) acc <= acc + op_a;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (op_a),
    .b   (op_b),
    .op  (op_c),
    .y   (alu_y),
    .err (alu_err)
  );

  // Result derives only from registers, so it stays stable through backpressure.
  assign res        = op_is_mul ? acc : alu_y;
  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign rsp_valid  = state == RESP;
  assign rsp_result = rsp_valid ? res : '0;
  assign rsp_zero   = rsp_valid && (res == '0);
  assign rsp_err    = rsp_valid && alu_err && !op_is_mul;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: latency, backpressure, illegal ops, mid-MUL reset.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [W-1:0] req_a, req_b;
  logic [3:0]   req_op;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_err, busy;

  int n_chk = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W), .MUL_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, check it, optionally
  // hold rsp_ready low for 'hold' extra cycles, then complete the handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input logic [W-1:0] exp, input logic ez,
                        input logic ee, input int exp_lat, input int hold);
    int lat;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; rsp_ready = 1'b0;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    // Garbage on the operand bus after accept must not leak into the result.
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
      else begin
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".ready_low"}, 64'(req_ready), 64'd0);
      end
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".result"}, 64'(rsp_result), 64'(exp));
    chk({tag, ".zero"}, 64'(rsp_zero), 64'(ez));
    chk({tag, ".err"}, 64'(rsp_err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, ".hold_result"}, 64'(rsp_result), 64'(exp));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int spurious;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    #1;
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.result", 64'(rsp_result), 64'd0);
    chk("rst.zero", 64'(rsp_zero), 64'd0);
    chk("rst.err", 64'(rsp_err), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.ready", 64'(req_ready), 64'd1);

    run_op("and",   32'hFFFF0000, 32'h00FFFF00, 4'b0000, 32'h00FF0000, 1'b0, 1'b0, 1, 0);
    run_op("addwr", 32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b0, 1, 0);
    run_op("slt1",  32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1, 0);
    run_op("slt0",  32'h00000001, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1, 0);
    run_op("sub",   32'h00000005, 32'h00000007, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 1, 0);
    run_op("nor",   32'h0F0F0F0F, 32'h00F000F0, 4'b1100, 32'hF000F000, 1'b0, 1'b0, 1, 0);
    run_op("or_bp", 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b0001, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 5);
    run_op("ill_f", 32'h12345678, 32'h9ABCDEF0, 4'b1111, 32'h00000000, 1'b1, 1'b1, 1, 0);
    run_op("ill_3", 32'h00000001, 32'h00000001, 4'b0011, 32'h00000000, 1'b1, 1'b1, 1, 0);
    run_op("mul",   32'h00001234, 32'h00000010, 4'b1000, 32'h00012340, 1'b0, 1'b0, 33, 0);
    run_op("mulff", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 32'h00000001, 1'b0, 1'b0, 33, 2);
    run_op("mul0",  32'h00000000, 32'h00000005, 4'b1000, 32'h00000000, 1'b1, 1'b0, 33, 0);

    // Abort a multiply with reset partway through.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h00001234; req_b = 32'h00000010; req_op = 4'b1000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort.busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort.valid", 64'(rsp_valid), 64'd0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.result", 64'(rsp_result), 64'd0);
    chk("abort.zero", 64'(rsp_zero), 64'd0);
    chk("abort.err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    chk("abort.no_rsp", 64'(spurious), 64'd0);
    run_op("add_post", 32'h00000002, 32'h00000003, 4'b0010, 32'h00000005, 1'b0, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
